// File: rtl/game_cfg_pkg.sv
// Shared configuration for the console game selector: FSM states,
// game index constants and default timing values.
package game_cfg_pkg;

  // Selector FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHORD    = 3'd1,
    ST_SWITCH   = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_LOCKOUT  = 3'd4
  } sel_state_t;

  // Default game slot assignments.
  localparam int GAME_PONG   = 0;
  localparam int GAME_SNAKE  = 1;
  localparam int GAME_FLAPPY = 2;
  localparam int GAME_PACMAN = 3;

  // Default sizing: 2 s hold at a 9 MHz pixel clock, four games.
  localparam int HOLD_2S_AT_9MHZ   = 18_000_000;
  localparam int NUM_GAMES_DEFAULT = 4;

  // Advance a game index, wrapping at numGames (need not be a power of two).
  function automatic int wrapInc(input int mode, input int numGames);
    return (mode == numGames - 1) ? 0 : mode + 1;
  endfunction

endpackage

// File: rtl/game_select_ctrl.sv
// Game-selection controller: a long two-button chord advances the game
// mode, pulses a reset to the new game and hides the gesture from games.
module game_select_ctrl
  import game_cfg_pkg::*;
#(
  parameter int NUM_GAMES   = NUM_GAMES_DEFAULT,
  parameter int MODE_W      = 2,
  parameter int HOLD_CYCLES = HOLD_2S_AT_9MHZ,
  parameter int LOCK_CYCLES = 900_000,
  parameter int CNT_W       = 25
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic                 btn_a,
  input  logic                 btn_b,
  output logic [MODE_W-1:0]    game_mode,
  output logic [NUM_GAMES-1:0] game_active,
  output logic                 mode_changed,
  output logic                 game_reset,
  output logic                 btn_a_out,
  output logic                 btn_b_out
);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(GAME_PONG);

  // Parameter sanity checks, evaluated at elaboration.
  if (NUM_GAMES < 2) begin : gChkGames
    $error("game_select_ctrl: NUM_GAMES must be at least 2");
  end
  if ((longint'(1) << MODE_W) < longint'(NUM_GAMES)) begin : gChkModeW
    $error("game_select_ctrl: MODE_W too narrow for NUM_GAMES");
  end
  if (HOLD_CYCLES < 2) begin : gChkHold
    $error("game_select_ctrl: HOLD_CYCLES must be at least 2");
  end
  if (LOCK_CYCLES < 0) begin : gChkLock
    $error("game_select_ctrl: LOCK_CYCLES must not be negative");
  end
  if ((longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(LOCK_CYCLES) >= (longint'(1) << CNT_W))) begin : gChkCntW
    $error("game_select_ctrl: CNT_W too narrow for HOLD_CYCLES/LOCK_CYCLES");
  end

  sel_state_t           r_state, w_stateNext;
  logic [CNT_W-1:0]     r_cnt, w_cntNext;
  logic [MODE_W-1:0]    r_mode, w_modeNext;
  logic [NUM_GAMES-1:0] r_active, w_activeNext;
  logic                 r_pulse, w_pulseNext;
  logic                 r_btnA, w_btnANext;
  logic                 r_btnB, w_btnBNext;
  logic                 w_both, w_any;

  assign w_both = btn_a & btn_b;
  assign w_any  = btn_a | btn_b;

  // Next-state, shared counter, mode and registered-output values.
  // While chording the counter holds the number of consecutive both-held
  // samples, including the IDLE sample that armed the chord.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_modeNext  = r_mode;
    w_pulseNext = 1'b0;
    w_btnANext  = 1'b0;
    w_btnBNext  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_both) begin
          w_stateNext = ST_CHORD;
          w_cntNext   = CNT_W'(1);
        end else begin
          w_btnANext = btn_a;
          w_btnBNext = btn_b;
          w_cntNext  = '0;
        end
      end
      ST_CHORD: begin
        if (!w_both) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_stateNext = ST_SWITCH;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      ST_SWITCH: begin
        w_modeNext  = MODE_W'(wrapInc(int'(r_mode), NUM_GAMES));
        w_pulseNext = 1'b1;
        w_stateNext = ST_WAIT_REL;
        w_cntNext   = '0;
      end
      ST_WAIT_REL: begin
        if (!w_any) begin
          w_stateNext = (LOCK_CYCLES == 0) ? ST_IDLE : ST_LOCKOUT;
          w_cntNext   = '0;
        end
      end
      ST_LOCKOUT: begin
        if (w_any) begin
          w_cntNext = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end
    endcase
    w_activeNext = NUM_GAMES'(1) << w_modeNext;
  end

  // State, counter and all outputs registered; reset returns to game 0.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mode   <= MODE_RST;
      r_active <= NUM_GAMES'(1) << MODE_RST;
      r_pulse  <= 1'b0;
      r_btnA   <= 1'b0;
      r_btnB   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_mode   <= w_modeNext;
      r_active <= w_activeNext;
      r_pulse  <= w_pulseNext;
      r_btnA   <= w_btnANext;
      r_btnB   <= w_btnBNext;
    end
  end

  assign game_mode    = r_mode;
  assign game_active  = r_active;
  assign mode_changed = r_pulse;
  assign game_reset   = r_pulse;
  assign btn_a_out    = r_btnA;
  assign btn_b_out    = r_btnB;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Self-checking bench for game_select_ctrl: directed gesture scenarios
// followed by random button traffic, compared against a behavioural model.
module tb_game_select_ctrl;

  localparam int NUM_GAMES = 3;
  localparam int MODE_W    = 2;
  localparam int HOLD      = 8;
  localparam int LOCK      = 4;
  localparam int CNT_W     = 4;

  logic                 clk_pix;
  logic                 rst_n;
  logic                 btn_a;
  logic                 btn_b;
  logic [MODE_W-1:0]    game_mode;
  logic [NUM_GAMES-1:0] game_active;
  logic                 mode_changed;
  logic                 game_reset;
  logic                 btn_a_out;
  logic                 btn_b_out;

  int nVectors     = 0;
  int nMiscompares = 0;

  // Behavioural model state: gesture described by run lengths and flags.
  int mMode;
  bit mPulse, mOutA, mOutB;
  bit masked;        // games do not see buttons
  bit switchNow;     // full hold reached, mode advances on next edge
  bit afterSwitch;   // switch done, waiting for release + quiet period
  bit quietStarted;  // release has been seen
  int heldRun;       // consecutive both-held samples of the current chord
  int quiet;         // consecutive quiet samples since release / last press

  game_select_ctrl #(
    .NUM_GAMES  (NUM_GAMES),
    .MODE_W     (MODE_W),
    .HOLD_CYCLES(HOLD),
    .LOCK_CYCLES(LOCK),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .btn_a       (btn_a),
    .btn_b       (btn_b),
    .game_mode   (game_mode),
    .game_active (game_active),
    .mode_changed(mode_changed),
    .game_reset  (game_reset),
    .btn_a_out   (btn_a_out),
    .btn_b_out   (btn_b_out)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  task automatic modelReset();
    mMode = 0; mPulse = 0; mOutA = 0; mOutB = 0;
    masked = 0; switchNow = 0; afterSwitch = 0; quietStarted = 0;
    heldRun = 0; quiet = 0;
  endtask

  // One rising edge of the model with the sampled button levels.
  task automatic modelEdge(input bit a, input bit b);
    mPulse = 0; mOutA = 0; mOutB = 0;
    if (switchNow) begin
      mMode = (mMode + 1) % NUM_GAMES;
      mPulse = 1;
      switchNow = 0;
      afterSwitch = 1;
      quietStarted = 0;
    end else if (!masked) begin
      if (a && b) begin
        masked = 1;
        heldRun = 1;
      end else begin
        mOutA = a;
        mOutB = b;
      end
    end else if (!afterSwitch) begin
      if (!(a && b)) begin
        masked = 0;
        heldRun = 0;
      end else begin
        heldRun++;
        if (heldRun == HOLD) switchNow = 1;
      end
    end else if (!quietStarted) begin
      if (!(a || b)) begin
        quietStarted = 1;
        quiet = 0;
        if (LOCK == 0) begin
          masked = 0; afterSwitch = 0; quietStarted = 0;
        end
      end
    end else begin
      if (a || b) quiet = 0;
      else begin
        quiet++;
        if (quiet == LOCK) begin
          masked = 0; afterSwitch = 0; quietStarted = 0;
        end
      end
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, "/mode"},   32'(game_mode),    32'(mMode));
    compare({tag, "/active"}, 32'(game_active),  32'(1) << mMode);
    compare({tag, "/chg"},    32'(mode_changed), 32'(mPulse));
    compare({tag, "/grst"},   32'(game_reset),   32'(mPulse));
    compare({tag, "/aout"},   32'(btn_a_out),    32'(mOutA));
    compare({tag, "/bout"},   32'(btn_b_out),    32'(mOutB));
  endtask

  // Drive buttons at the falling edge, model the rising edge, check after.
  task automatic applyStimulus(input string tag, input bit a, input bit b);
    btn_a = a;
    btn_b = b;
    @(posedge clk_pix);
    modelEdge(a, b);
    @(negedge clk_pix);
    checkOutput(tag);
  endtask

  task automatic repeatStimulus(input string tag, input int n, input bit a, input bit b);
    for (int i = 0; i < n; i++) applyStimulus(tag, a, b);
  endtask

  // Asynchronous reset asserted between clock edges and checked at once.
  task automatic asyncReset(input string tag);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput(tag);
    @(negedge clk_pix);
    btn_a = 1'b0;
    btn_b = 1'b0;
    rst_n = 1'b1;
  endtask

  // One full chord followed by enough release to finish the lockout.
  task automatic fullChord(input string tag);
    repeatStimulus(tag, HOLD, 1'b1, 1'b1);
    repeatStimulus(tag, LOCK + 2, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    modelReset();
    repeat (2) @(negedge clk_pix);
    checkOutput("reset");
    compare("resetActive", 32'(game_active), 32'h1);
    rst_n = 1'b1;

    // Single button passes through and never arms the chord.
    repeatStimulus("aAlone", 20, 1'b1, 1'b0);
    compare("aAloneOut", 32'(btn_a_out), 32'h1);
    repeatStimulus("idle", 2, 1'b0, 1'b0);

    // Full hold: switch appears on the edge after the last held sample.
    repeatStimulus("hold", HOLD, 1'b1, 1'b1);
    compare("holdMasked", 32'(btn_a_out), 32'h0);
    applyStimulus("switch", 1'b0, 1'b0);
    compare("switchMode", 32'(game_mode), 32'h1);
    compare("switchActive", 32'(game_active), 32'h2);
    compare("switchPulse", 32'(mode_changed), 32'h1);
    applyStimulus("pulseEnd", 1'b0, 1'b0);
    compare("pulseOneCycle", 32'(game_reset), 32'h0);
    repeatStimulus("lock", LOCK + 2, 1'b0, 1'b0);

    // Drop one button on the final chord edge: no switch.
    repeatStimulus("short", HOLD - 1, 1'b1, 1'b1);
    repeatStimulus("abort", 3, 1'b1, 1'b0);
    compare("abortMode", 32'(game_mode), 32'h1);
    compare("abortPass", 32'(btn_a_out), 32'h1);
    repeatStimulus("idle", 2, 1'b0, 1'b0);

    // Three chords from game 0 walk 1, 2 and wrap to 0.
    asyncReset("rst2");
    fullChord("chord1");
    compare("wrap1", 32'(game_active), 32'h2);
    fullChord("chord2");
    compare("wrap2", 32'(game_active), 32'h4);
    fullChord("chord3");
    compare("wrap3", 32'(game_active), 32'h1);

    // Long hold switches once; a press during lockout restarts it.
    repeatStimulus("long", 30, 1'b1, 1'b1);
    compare("longOnce", 32'(game_mode), 32'h1);
    repeatStimulus("rel", 3, 1'b0, 1'b0);
    applyStimulus("lockPress", 1'b1, 1'b0);
    repeatStimulus("relock", LOCK, 1'b0, 1'b0);
    repeatStimulus("relockA", 2, 1'b1, 1'b0);
    compare("relockPass", 32'(btn_a_out), 32'h1);
    repeatStimulus("idle", 2, 1'b0, 1'b0);

    // Reach game 2, then reset in the middle of a chord.
    fullChord("toTwo");
    compare("atTwo", 32'(game_mode), 32'h2);
    repeatStimulus("midChord", 6, 1'b1, 1'b1);
    asyncReset("rstMid");
    compare("rstMidMode", 32'(game_mode), 32'h0);

    // Random button traffic in runs, with one asynchronous reset inserted.
    for (int seg = 0; seg < 80; seg++) begin
      int pat;
      int len;
      pat = $urandom_range(0, 3);
      len = $urandom_range(1, 12);
      if (seg == 40) asyncReset("rndRst");
      repeatStimulus("rnd", len, pat[0], pat[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
